// File: rtl/pe_cmd_sequencer.sv
// pe_cmd_sequencer: initiator side of the PE command interface. Runs one
// dot-product job: RESET, SET_CONV_MODE, optional LOAD_DATA, one TRIGGER
// per operand beat (TRIGGER_LAST on the final beat of multi-beat jobs), then
// waits for the PE to go idle and hands back its accumulator.
// Build option: define PESEQ_PRELOAD_EN to issue LOAD_DATA with the job bias.
//
// state  | meaning
// IDLE   | waiting for a job with nonzero length
// RST    | RESET command on the bus
// CFG    | SET_CONV_MODE carrying the job length
// PRE    | LOAD_DATA carrying the bias (PESEQ_PRELOAD_EN builds only)
// STREAM | accepting operand beats, one command per handshake
// DRAIN  | waiting for PE busy to fall, bounded by DRAIN_TIMEOUT
// RESULT | holding the result until the consumer accepts it
module pe_cmd_sequencer #(
  parameter int ACLEN         = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int LEN_WIDTH     = 16,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [DATA_WIDTH-1:0] bias_i,
  output logic                  idle_o,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [DATA_WIDTH-1:0] in_weight_i,
  output logic                  pe_cmd_valid_o,
  output logic [ACLEN:0]        pe_cmd_o,
  output logic [DATA_WIDTH-1:0] param_1_o,
  output logic [DATA_WIDTH-1:0] param_2_o,
  output logic [DATA_WIDTH-1:0] preload_data_o,
  output logic [DATA_WIDTH-1:0] pe_data_o,
  output logic [DATA_WIDTH-1:0] pe_weight_o,
  input  logic                  pe_busy_i,
  input  logic [DATA_WIDTH-1:0] pe_mac_value_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [DATA_WIDTH-1:0] res_data_o,
  output logic                  res_timeout_o
);

  localparam int CW = ACLEN + 1;
  // drain timer counts down from DRAIN_TIMEOUT-1; terminal count 0 = timeout
  localparam int TW = (DRAIN_TIMEOUT > 4) ? $clog2(DRAIN_TIMEOUT) : 2;
  localparam logic [TW-1:0] TMR_LOAD  = TW'(DRAIN_TIMEOUT - 1);
  // two cycles elapsed: PE busy has had time to assert after the last beat
  localparam logic [TW-1:0] TMR_ARMED = TW'(DRAIN_TIMEOUT - 3);

  localparam logic [CW-1:0] CMD_RESET        = CW'(0);
  localparam logic [CW-1:0] CMD_TRIGGER      = CW'(1);
  localparam logic [CW-1:0] CMD_TRIGGER_LAST = CW'(2);
  localparam logic [CW-1:0] CMD_LOAD_DATA    = CW'(5);
  localparam logic [CW-1:0] CMD_SET_CONV     = CW'(6);

`ifdef PESEQ_PRELOAD_EN
  typedef enum logic [2:0] {IDLE, RST, CFG, PRE, STREAM, DRAIN, RESULT} state_t;
`else
  typedef enum logic [2:0] {IDLE, RST, CFG, STREAM, DRAIN, RESULT} state_t;
`endif

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beats_q, beats_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic                  idle_d, in_ready_d, cmd_valid_d, res_valid_d, res_timeout_d;
  logic [CW-1:0]         cmd_d;
  logic [DATA_WIDTH-1:0] param_1_d, data_d, weight_d, res_data_d;
`ifdef PESEQ_PRELOAD_EN
  logic [DATA_WIDTH-1:0] bias_q, bias_d, preload_d;
`else
  logic unused_bias;
  assign unused_bias    = ^bias_i;
  assign preload_data_o = '0;
`endif

  assign param_2_o = '0;

  // next-state and next-output decode; outputs are registered from these
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    beats_d       = beats_q;
    tmr_d         = tmr_q;
    cmd_valid_d   = 1'b0;
    cmd_d         = CMD_RESET;
    param_1_d     = '0;
    data_d        = pe_data_o;
    weight_d      = pe_weight_o;
    res_valid_d   = res_valid_o;
    res_data_d    = res_data_o;
    res_timeout_d = res_timeout_o;
`ifdef PESEQ_PRELOAD_EN
    bias_d        = bias_q;
    preload_d     = preload_data_o;
`endif
    case (state_q)
      IDLE: begin
        if (start_i && (len_i != '0)) begin
          len_d       = len_i;
          beats_d     = len_i;
`ifdef PESEQ_PRELOAD_EN
          bias_d      = bias_i;
`endif
          cmd_valid_d = 1'b1;
          cmd_d       = CMD_RESET;
          state_d     = RST;
        end
      end
      RST: begin
        cmd_valid_d = 1'b1;
        cmd_d       = CMD_SET_CONV;
        param_1_d   = DATA_WIDTH'(len_q);
        state_d     = CFG;
      end
`ifdef PESEQ_PRELOAD_EN
      CFG: begin
        cmd_valid_d = 1'b1;
        cmd_d       = CMD_LOAD_DATA;
        preload_d   = bias_q;
        state_d     = PRE;
      end
      PRE: state_d = STREAM;
`else
      CFG: state_d = STREAM;
`endif
      STREAM: begin
        if (in_valid_i && in_ready_o) begin
          cmd_valid_d = 1'b1;
          data_d      = in_data_i;
          weight_d    = in_weight_i;
          beats_d     = beats_q - LEN_WIDTH'(1);
          cmd_d       = CMD_TRIGGER;
          if (beats_q == LEN_WIDTH'(1)) begin
            if (len_q != LEN_WIDTH'(1)) cmd_d = CMD_TRIGGER_LAST;
            tmr_d   = TMR_LOAD;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if ((tmr_q <= TMR_ARMED) && !pe_busy_i) begin
          res_valid_d   = 1'b1;
          res_data_d    = pe_mac_value_i;
          res_timeout_d = 1'b0;
          state_d       = RESULT;
        end else if (tmr_q == '0) begin
          res_valid_d   = 1'b1;
          res_data_d    = pe_mac_value_i;
          res_timeout_d = 1'b1;
          state_d       = RESULT;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      RESULT: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    idle_d     = (state_d == IDLE);
    in_ready_d = (state_d == STREAM);
  end

  // state, counters and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      len_q          <= '0;
      beats_q        <= '0;
      tmr_q          <= '0;
      idle_o         <= 1'b1;
      in_ready_o     <= 1'b0;
      pe_cmd_valid_o <= 1'b0;
      pe_cmd_o       <= '0;
      param_1_o      <= '0;
      pe_data_o      <= '0;
      pe_weight_o    <= '0;
      res_valid_o    <= 1'b0;
      res_data_o     <= '0;
      res_timeout_o  <= 1'b0;
`ifdef PESEQ_PRELOAD_EN
      bias_q         <= '0;
      preload_data_o <= '0;
`endif
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      beats_q        <= beats_d;
      tmr_q          <= tmr_d;
      idle_o         <= idle_d;
      in_ready_o     <= in_ready_d;
      pe_cmd_valid_o <= cmd_valid_d;
      pe_cmd_o       <= cmd_d;
      param_1_o      <= param_1_d;
      pe_data_o      <= data_d;
      pe_weight_o    <= weight_d;
      res_valid_o    <= res_valid_d;
      res_data_o     <= res_data_d;
      res_timeout_o  <= res_timeout_d;
`ifdef PESEQ_PRELOAD_EN
      bias_q         <= bias_d;
      preload_data_o <= preload_d;
`endif
    end
  end

endmodule
